// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU sequencer: instruction
// classes, jump condition codes, sequencer states and instruction-field slices.
package cpu_pkg;

  typedef enum logic [3:0] {
    C_NOP  = 4'h0,
    C_ALU  = 4'h1,
    C_LDI  = 4'h2,
    C_JMP  = 4'h3,
    C_HALT = 4'hF
  } cls_e;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_Z  = 4'd1;
  localparam logic [3:0] CC_NZ = 4'd2;
  localparam logic [3:0] CC_C  = 4'd3;
  localparam logic [3:0] CC_NC = 4'd4;
  localparam logic [3:0] CC_S  = 4'd5;
  localparam logic [3:0] CC_NS = 4'd6;
  localparam logic [3:0] CC_V  = 4'd7;
  localparam logic [3:0] CC_NV = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam int CLS_MSB = 15;
  localparam int CLS_LSB = 12;
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Classes 4..E are undefined; the sequencer flags them and stops.
  function automatic logic is_illegal_cls(input logic [3:0] cls);
    return (cls >= 4'h4) && (cls <= 4'hE);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Jump condition evaluation: maps a 4-bit condition code and the four CPU
// flags to a taken/not-taken decision. Purely combinational.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [3:0] cc,
  input  logic       cy,
  input  logic       ov,
  input  logic       zf,
  input  logic       sf,
  output logic       taken
);

  // NOTE: assign a default at the top of every always_comb so no path leaves
  // an output unassigned; a missing default infers a latch.
  always_comb begin
    taken = 1'b0;
    case (cc)
      CC_AL:   taken = 1'b1;
      CC_Z:    taken = zf;
      CC_NZ:   taken = ~zf;
      CC_C:    taken = cy;
      CC_NC:   taken = ~cy;
      CC_S:    taken = sf;
      CC_NS:   taken = ~sf;
      CC_V:    taken = ov;
      CC_NV:   taken = ~ov;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute controller for the 8-bit accumulator CPU: fetches
// 16-bit words over req/ack, decodes them and resolves conditional jumps.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  input  logic            cy,
  input  logic            ov,
  input  logic            zf,
  input  logic            sf,
  output logic [3:0]      alu_op,
  output logic [7:0]      imm,
  output logic            sel_imm,
  output logic            acc_we,
  output logic            ce_cy,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [IW-1:0]   ir_q;
  logic            illegal_q;

  logic [3:0]      cls;
  logic [3:0]      cc;
  logic [PC_W-1:0] target;
  logic            cond_taken;
  logic            jump_taken;
  logic            cls_illegal;

  assign cls         = ir_q[CLS_MSB:CLS_LSB];
  assign cc          = ir_q[OP_MSB:OP_LSB];
  assign target      = PC_W'(ir_q[IMM_MSB:IMM_LSB]);
  assign cls_illegal = is_illegal_cls(cls);
  assign jump_taken  = (cls == C_JMP) && cond_taken;

  branch_cond u_branch_cond (
    .cc    (cc),
    .cy    (cy),
    .ov    (ov),
    .zf    (zf),
    .sf    (sf),
    .taken (cond_taken)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_EXEC;
      S_EXEC:  state_d = ((cls == C_HALT) || cls_illegal) ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // The flags block captures at the end of EXEC, so the next JMP already
  // sees the flags produced by a preceding ALU op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      if ((state_q == S_FETCH) && imem_ack) begin
        ir_q <= imem_data;
      end
      if (state_q == S_EXEC) begin
        pc_q <= jump_taken ? target : pc_q + PC_W'(1);
        if (cls_illegal) begin
          illegal_q <= 1'b1;
        end
      end
    end
  end

  // Decode outputs are gated to EXEC so the datapath never sees stale ir.
  always_comb begin
    imem_req = (state_q == S_FETCH);
    halted   = (state_q == S_HALT);
    alu_op   = 4'h0;
    imm      = 8'h00;
    sel_imm  = 1'b0;
    acc_we   = 1'b0;
    ce_cy    = 1'b0;
    if (state_q == S_EXEC) begin
      imm = ir_q[IMM_MSB:IMM_LSB];
      case (cls)
        C_ALU: begin
          alu_op = ir_q[OP_MSB:OP_LSB];
          acc_we = 1'b1;
          ce_cy  = 1'b1;
        end
        C_LDI: begin
          acc_we  = 1'b1;
          sel_imm = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a program-memory responder, a
// scoreboard queue of expected EXEC results and a monitor that pops it.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [15:0]     imem_data = 16'h0000;
  logic            cy, ov, zf, sf;
  logic [3:0]      alu_op;
  logic [7:0]      imm;
  logic            sel_imm, acc_we, ce_cy;
  logic [PC_W-1:0] pc;
  logic            halted, illegal;

  logic [15:0] mem      [0:255];
  logic [3:0]  flag_tab [0:255];

  int  checks = 0;
  int  errors = 0;
  int  ack_delay = 0;
  int  ack_budget = 1000;
  int  req_cycles = 0;
  int  last_req_len = 0;
  bit  stray_ack = 1'b0;
  bit  mon_busy = 1'b0;
  logic [7:0] held_addr = 8'h00;

  typedef struct {
    string      name;
    logic       acc_we;
    logic       sel_imm;
    logic       ce_cy;
    logic       chk_op;
    logic [3:0] alu_op;
    logic       chk_imm;
    logic [7:0] imm;
    logic [7:0] pc_next;
    logic       halted;
    logic       illegal;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [3:0] cc;
    logic [3:0] flags;  // {cy, ov, zf, sf}
    logic       taken;
  } jvec_t;

  jvec_t jvecs[$];

  // Flags seen by the sequencer depend on the address of the executing word.
  assign {cy, ov, zf, sf} = flag_tab[pc];

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(PC_W), .IW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .cy        (cy),
    .ov        (ov),
    .zf        (zf),
    .sf        (sf),
    .alu_op    (alu_op),
    .imm       (imm),
    .sel_imm   (sel_imm),
    .acc_we    (acc_we),
    .ce_cy     (ce_cy),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic we, input logic sel, input logic ce,
                          input logic chk_op, input logic [3:0] op,
                          input logic chk_imm, input logic [7:0] im,
                          input logic [7:0] pcn, input logic hlt, input logic ill);
    exp_t e;
    e.name    = name;
    e.acc_we  = we;
    e.sel_imm = sel;
    e.ce_cy   = ce;
    e.chk_op  = chk_op;
    e.alu_op  = op;
    e.chk_imm = chk_imm;
    e.imm     = im;
    e.pc_next = pcn;
    e.halted  = hlt;
    e.illegal = ill;
    exp_q.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i]      = 16'hF000;
      flag_tab[i] = 4'h0;
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    stray_ack  = 1'b0;
    ack_delay  = 0;
    ack_budget = 1000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_prog(input string name);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while ((exp_q.size() != 0 || mon_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, ".all_exec_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Program memory responder: acks after ack_delay waiting cycles, optionally
  // drives a stray ack with junk data while no fetch is requested.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (req_cycles == 0) begin
          held_addr = imem_addr;
        end else begin
          check("fetch_addr_stable", 32'(imem_addr), 32'(held_addr));
          check("fetch_no_acc_we", 32'(acc_we), 32'd0);
        end
        imem_data = mem[imem_addr];
        imem_ack  = 1'b0;
        if (req_cycles >= ack_delay && ack_budget > 0) begin
          imem_ack     = 1'b1;
          ack_budget   = ack_budget - 1;
          last_req_len = req_cycles + 1;
        end
        req_cycles++;
      end else begin
        req_cycles = 0;
        imem_ack   = stray_ack;
        imem_data  = 16'h2FEE;
      end
    end
  end

  // Monitor: each completed fetch must be followed by one EXEC cycle whose
  // decode matches the next scoreboard entry, then the resulting pc/status.
  initial begin : monitor
    exp_t e;
    @(negedge clk);
    #1;
    forever begin
      if (rst_n && imem_req && imem_ack) begin
        mon_busy = 1'b1;
        @(negedge clk);
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exec: got an EXEC at pc 0x%0h, expected none", pc);
          @(negedge clk);
          #1;
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".acc_we"}, 32'(acc_we), 32'(e.acc_we));
          check({e.name, ".sel_imm"}, 32'(sel_imm), 32'(e.sel_imm));
          check({e.name, ".ce_cy"}, 32'(ce_cy), 32'(e.ce_cy));
          check({e.name, ".no_req_in_exec"}, 32'(imem_req), 32'd0);
          if (e.chk_op) check({e.name, ".alu_op"}, 32'(alu_op), 32'(e.alu_op));
          if (e.chk_imm) check({e.name, ".imm"}, 32'(imm), 32'(e.imm));
          @(negedge clk);
          #1;
          check({e.name, ".pc_next"}, 32'(pc), 32'(e.pc_next));
          check({e.name, ".halted"}, 32'(halted), 32'(e.halted));
          check({e.name, ".illegal"}, 32'(illegal), 32'(e.illegal));
          check({e.name, ".acc_we_one_cycle"}, 32'(acc_we), 32'd0);
          check({e.name, ".ce_cy_one_cycle"}, 32'(ce_cy), 32'd0);
        end
        mon_busy = 1'b0;
      end else begin
        @(negedge clk);
        #1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    clear_prog();

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.imem_req", 32'(imem_req), 32'd0);
    check("rst.acc_we", 32'(acc_we), 32'd0);
    check("rst.ce_cy", 32'(ce_cy), 32'd0);
    check("rst.sel_imm", 32'(sel_imm), 32'd0);
    check("rst.alu_op", 32'(alu_op), 32'd0);
    check("rst.imm", 32'(imm), 32'd0);
    check("rst.pc", 32'(pc), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.no_req", 32'(imem_req), 32'd0);

    // LDI 0x05 / HALT, same-cycle ack: halted on the fifth cycle after start
    clear_prog();
    mem[0] = 16'h2005;
    mem[1] = 16'hF000;
    push_exp("ldi", 1, 1, 0, 0, 4'h0, 1, 8'h05, 8'h01, 0, 0);
    push_exp("ldi_halt", 0, 0, 0, 0, 4'h0, 0, 8'h00, 8'h02, 1, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ldi.halted_by_cycle5", 32'(halted), 32'd1);
    repeat (3) @(negedge clk);
    check("ldi.pc_frozen", 32'(pc), 32'd2);
    check("ldi.halt_no_req", 32'(imem_req), 32'd0);
    check("ldi.queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // ALU op 0xA
    do_reset();
    clear_prog();
    mem[0] = 16'h1A33;
    push_exp("alu", 1, 0, 1, 1, 4'hA, 0, 8'h00, 8'h01, 0, 0);
    push_exp("alu_halt", 0, 0, 0, 0, 4'h0, 0, 8'h00, 8'h02, 1, 0);
    run_prog("alu");

    // Conditional jumps: flag under test at the tested polarity, others inverted
    jvecs.push_back('{4'd0, 4'b0000, 1'b1});
    jvecs.push_back('{4'd0, 4'b1111, 1'b1});
    jvecs.push_back('{4'd1, 4'b0010, 1'b1});
    jvecs.push_back('{4'd1, 4'b1101, 1'b0});
    jvecs.push_back('{4'd2, 4'b1101, 1'b1});
    jvecs.push_back('{4'd2, 4'b0010, 1'b0});
    jvecs.push_back('{4'd3, 4'b1000, 1'b1});
    jvecs.push_back('{4'd3, 4'b0111, 1'b0});
    jvecs.push_back('{4'd4, 4'b0111, 1'b1});
    jvecs.push_back('{4'd4, 4'b1000, 1'b0});
    jvecs.push_back('{4'd5, 4'b0001, 1'b1});
    jvecs.push_back('{4'd5, 4'b1110, 1'b0});
    jvecs.push_back('{4'd6, 4'b1110, 1'b1});
    jvecs.push_back('{4'd6, 4'b0001, 1'b0});
    jvecs.push_back('{4'd7, 4'b0100, 1'b1});
    jvecs.push_back('{4'd7, 4'b1011, 1'b0});
    jvecs.push_back('{4'd8, 4'b1011, 1'b1});
    jvecs.push_back('{4'd8, 4'b0100, 1'b0});
    jvecs.push_back('{4'd9, 4'b1111, 1'b0});
    jvecs.push_back('{4'd9, 4'b0000, 1'b0});
    jvecs.push_back('{4'd15, 4'b1111, 1'b0});
    foreach (jvecs[i]) begin
      string nm;
      nm = $sformatf("jmp_cc%0d_f%04b", jvecs[i].cc, jvecs[i].flags);
      do_reset();
      clear_prog();
      mem[0]      = {4'h3, jvecs[i].cc, 8'h40};
      flag_tab[0] = jvecs[i].flags;
      push_exp(nm, 0, 0, 0, 0, 4'h0, 0, 8'h00,
               jvecs[i].taken ? 8'h40 : 8'h01, 0, 0);
      push_exp({nm, "_halt"}, 0, 0, 0, 0, 4'h0, 0, 8'h00,
               jvecs[i].taken ? 8'h41 : 8'h02, 1, 0);
      run_prog(nm);
    end

    // Ack delayed three cycles, stray ack outside FETCH
    do_reset();
    clear_prog();
    ack_delay = 3;
    stray_ack = 1'b1;
    mem[0] = 16'h2011;
    mem[1] = 16'h1233;
    push_exp("dly_ldi", 1, 1, 0, 0, 4'h0, 1, 8'h11, 8'h01, 0, 0);
    push_exp("dly_alu", 1, 0, 1, 1, 4'h2, 0, 8'h00, 8'h02, 0, 0);
    push_exp("dly_halt", 0, 0, 0, 0, 4'h0, 0, 8'h00, 8'h03, 1, 0);
    run_prog("dly");
    check("dly.req_len", 32'(last_req_len), 32'd4);

    // Undefined class 7: illegal and halted, later start ignored
    do_reset();
    clear_prog();
    mem[0] = 16'h7123;
    push_exp("ill", 0, 0, 0, 0, 4'h0, 0, 8'h00, 8'h01, 1, 1);
    run_prog("ill");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ill.still_halted", 32'(halted), 32'd1);
    check("ill.still_illegal", 32'(illegal), 32'd1);
    check("ill.pc_frozen", 32'(pc), 32'd1);
    check("ill.no_req", 32'(imem_req), 32'd0);

    // PC wrap 0xFF -> 0x00, then reset while a fetch is stalled
    do_reset();
    clear_prog();
    ack_budget = 3;
    mem[8'h00] = 16'h30FE;
    mem[8'hFE] = 16'h0000;
    mem[8'hFF] = 16'h0000;
    push_exp("wrap_jmp", 0, 0, 0, 0, 4'h0, 0, 8'h00, 8'hFE, 0, 0);
    push_exp("wrap_nop_fe", 0, 0, 0, 0, 4'h0, 0, 8'h00, 8'hFF, 0, 0);
    push_exp("wrap_nop_ff", 0, 0, 0, 0, 4'h0, 0, 8'h00, 8'h00, 0, 0);
    run_prog("wrap");
    repeat (2) @(negedge clk);
    check("wrap.stalled_req", 32'(imem_req), 32'd1);
    check("wrap.stalled_addr", 32'(imem_addr), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.req_drop", 32'(imem_req), 32'd0);
    check("midrst.pc", 32'(pc), 32'd0);
    ack_budget = 1000;
    stray_ack  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst.idle_no_req", 32'(imem_req), 32'd0);
    check("midrst.idle_pc", 32'(pc), 32'd0);
    check("midrst.idle_not_halted", 32'(halted), 32'd0);
    check("midrst.no_acc_we", 32'(acc_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
